// File: rtl/axi_lite_ring_writer_pkg.sv
// Shared types and constants for the axi_lite_ring_writer slice.
package ring_writer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR_DATA,
        RESP
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam logic [3:0] WSTRB_ALL     = 4'hF;

endpackage

// File: rtl/axi_lite_ring_writer_if.sv
// AXI4-Lite bundle used between the ring writer (m) and the HP0 slave (s).
interface axi4_lite_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport m (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport s (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi_lite_ring_writer_sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry an extra wrap bit for full/empty.
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en && !full)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/axi_lite_ring_writer.sv
// Stream-to-DDR ring writer issuing single-beat AXI4-Lite writes.
// Optional interrupt output enabled by defining RING_WR_IRQ_EN.
module axi_lite_ring_writer
    import ring_writer_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int IDX_W      = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              enable,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [IDX_W-1:0]  ring_len,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [IDX_W-1:0]  wr_idx,
    output logic [15:0]       wrap_cnt,
    output logic              busy,
    output logic              err,
    input  logic              err_clr,
`ifdef RING_WR_IRQ_EN
    input  logic [IDX_W-1:0]  irq_thresh,
    input  logic              irq_ack,
    output logic              irq,
`endif
    axi4_lite_if.m            axi
);
    state_t            state_q, state_d;
    logic              fifo_full, fifo_empty, fifo_wr;
    logic [DATA_W-1:0] fifo_dout;
    logic              ring_on;
    logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic              start, b_done;
    logic [ADDR_W-1:0] awaddr_q, addr_next;
    logic [DATA_W-1:0] wdata_q;
    logic [IDX_W:0]    idx_inc;
    logic [IDX_W-1:0]  idx_next;
    logic              wrap;

    assign ring_on = (ring_len != '0);
    // Gated by reset so the stream side reports not-ready while held in reset.
    assign s_ready = ~areset & ~fifo_full & ring_on;
    assign fifo_wr = s_valid & s_ready;
    assign busy    = (state_q != IDLE) | ~fifo_empty;

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .aclk    (aclk),
        .areset  (areset),
        .wr_en   (fifo_wr),
        .wr_data (s_data),
        .rd_en   (start),
        .rd_data (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        start     = 1'b0;
        b_done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable && !fifo_empty && ring_on) begin
                    start     = 1'b1;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = ADDR_DATA;
                end
            end
            ADDR_DATA: begin
                awvalid_d = awvalid_q & ~axi.awready;
                wvalid_d  = wvalid_q & ~axi.wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (axi.bvalid) begin
                    b_done   = 1'b1;
                    bready_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
        end
    end

    // Wrap on >= so a ring shrunk below the current index snaps back to 0.
    assign idx_inc   = {1'b0, wr_idx} + (IDX_W+1)'(1);
    assign wrap      = (idx_inc >= {1'b0, ring_len});
    assign idx_next  = wrap ? '0 : idx_inc[IDX_W-1:0];
    assign addr_next = {base_addr[ADDR_W-1:2], 2'b00} + ADDR_W'({wr_idx, 2'b00});

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            awaddr_q <= '0;
            wdata_q  <= '0;
            wr_idx   <= '0;
            wrap_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (start) begin
                awaddr_q <= addr_next;
                wdata_q  <= fifo_dout;
            end
            if (b_done) begin
                wr_idx <= idx_next;
                if (wrap)
                    wrap_cnt <= wrap_cnt + 16'd1;
            end
            if (b_done && axi.bresp != AXI_RESP_OKAY)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;
        end
    end

`ifdef RING_WR_IRQ_EN
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            irq <= 1'b0;
        else if (b_done && (wrap || idx_next == irq_thresh))
            irq <= 1'b1;
        else if (irq_ack)
            irq <= 1'b0;
    end
`endif

    assign axi.awaddr  = awaddr_q;
    assign axi.awprot  = 3'b000;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = WSTRB_ALL;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;
    assign axi.araddr  = '0;
    assign axi.arprot  = 3'b000;
    assign axi.arvalid = 1'b0;
    assign axi.rready  = 1'b1;

    logic unused_inputs;
    assign unused_inputs = ^{base_addr[1:0], axi.arready, axi.rdata, axi.rresp, axi.rvalid};
endmodule

// File: tb/tb_axi_lite_ring_writer.sv
// Scoreboard bench for axi_lite_ring_writer with a delay-programmable AXI slave.
module tb_axi_lite_ring_writer;
    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic        areset, enable, s_valid, s_ready, busy, err, err_clr;
    logic [31:0] base_addr, s_data;
    logic [15:0] ring_len, wr_idx, wrap_cnt;
`ifdef RING_WR_IRQ_EN
    logic [15:0] irq_thresh;
    logic        irq_ack, irq;
    assign irq_thresh = '0;
    assign irq_ack    = 1'b0;
`endif

    axi4_lite_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    axi_lite_ring_writer #(.ADDR_W(32), .DATA_W(32), .IDX_W(16), .FIFO_DEPTH(16)) dut (
        .aclk      (aclk),
        .areset    (areset),
        .enable    (enable),
        .base_addr (base_addr),
        .ring_len  (ring_len),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .wr_idx    (wr_idx),
        .wrap_cnt  (wrap_cnt),
        .busy      (busy),
        .err       (err),
        .err_clr   (err_clr),
`ifdef RING_WR_IRQ_EN
        .irq_thresh(irq_thresh),
        .irq_ack   (irq_ack),
        .irq       (irq),
`endif
        .axi       (axi)
    );

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q [$];
    logic [31:0] cap_addr [$];
    logic [31:0] cap_data [$];
    int aw_hs_cnt = 0, w_hs_cnt = 0, b_cnt = 0;
    int aw_delay = 0, w_delay = 0, bad_b_at = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // AXI slave: readies after programmable delays, B once both AW and W are done.
    initial begin
        bit aw_fired = 0, w_fired = 0, b_fired = 0, b_checked = 0;
        int aw_wait = 0, w_wait = 0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 2'b00;
        axi.arready = 0; axi.rdata = '0; axi.rresp = 2'b00; axi.rvalid = 0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
                aw_fired = 0; w_fired = 0; b_fired = 0; b_checked = 0;
                aw_wait = 0; w_wait = 0;
            end else begin
                if (b_fired) begin
                    axi.bvalid = 0; b_fired = 0; b_checked = 0;
                end else if (!axi.bvalid && aw_hs_cnt > b_cnt && w_hs_cnt > b_cnt) begin
                    axi.bvalid = 1;
                    axi.bresp  = (b_cnt == bad_b_at) ? 2'b10 : 2'b00;
                end
                if (axi.bready && !b_checked) begin
                    b_checked = 1;
                    chk("bready_after_aw", aw_hs_cnt, b_cnt + 1);
                    chk("bready_after_w", w_hs_cnt, b_cnt + 1);
                end
                if (axi.bvalid && axi.bready) begin
                    b_fired = 1; b_cnt++;
                end
                if (aw_fired) begin
                    axi.awready = 0; aw_fired = 0; aw_wait = 0;
                end else if (axi.awvalid) begin
                    if (aw_wait >= aw_delay) axi.awready = 1; else aw_wait++;
                end
                if (axi.awvalid && axi.awready) begin
                    aw_fired = 1; aw_hs_cnt++; cap_addr.push_back(axi.awaddr);
                end
                if (w_fired) begin
                    axi.wready = 0; w_fired = 0; w_wait = 0;
                end else if (axi.wvalid) begin
                    if (w_wait >= w_delay) axi.wready = 1; else w_wait++;
                end
                if (axi.wvalid && axi.wready) begin
                    w_fired = 1; w_hs_cnt++; cap_data.push_back(axi.wdata);
                    chk("wstrb", 32'(axi.wstrb), 32'hF);
                end
            end
        end
    end

    // Monitor: pair captured AW/W beats and compare against the scoreboard.
    initial begin
        logic [31:0] a, d;
        logic [63:0] e;
        forever begin
            @(posedge aclk);
            #2;
            while (cap_addr.size() > 0 && cap_data.size() > 0) begin
                a = cap_addr.pop_front();
                d = cap_data.pop_front();
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, required no write", a, d);
                end else begin
                    e = exp_q.pop_front();
                    chk("awaddr", a, e[63:32]);
                    chk("wdata", d, e[31:0]);
                end
            end
        end
    end

    task automatic push(input logic [31:0] d, input logic [31:0] a);
        int n = 0;
        @(negedge aclk);
        s_valid = 1; s_data = d;
        while (!s_ready && n < 500) begin
            @(negedge aclk); n++;
        end
        if (!s_ready) begin
            checks++; failures++;
            $display("FAIL push_timeout: s_ready=0 required 1");
        end else begin
            exp_q.push_back({a, d});
        end
        @(posedge aclk);
        #1 s_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge aclk); n++;
        end while ((busy || exp_q.size() != 0) && n < 3000);
        if (n >= 3000) begin
            checks++; failures++;
            $display("FAIL idle_timeout: busy=%0d pending=%0d required 0", busy, exp_q.size());
        end
    endtask

    task automatic do_reset();
        @(negedge aclk);
        areset = 1;
        repeat (2) @(negedge aclk);
        exp_q.delete(); cap_addr.delete(); cap_data.delete();
        areset = 0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_aw, base_w, base_b, n;
        bit any_ready, any_aw;
        areset = 1; enable = 0; s_valid = 0; s_data = '0; err_clr = 0;
        base_addr = 32'h1000_0000; ring_len = 16'd4;

        // Reset values while held in reset
        @(negedge aclk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_wr_idx", wr_idx, 0);
        chk("rst_wrap_cnt", wrap_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_awvalid", axi.awvalid, 0);
        chk("rst_wvalid", axi.wvalid, 0);
        chk("rst_bready", axi.bready, 0);
        chk("arvalid", axi.arvalid, 0);
        chk("rready", axi.rready, 1);
        @(negedge aclk);
        areset = 0;

        // One full ring of 4
        enable = 1;
        for (int unsigned i = 0; i < 4; i++)
            push(32'hA0 + i, 32'h1000_0000 + 4 * i);
        wait_idle();
        chk("t1_wr_idx", wr_idx, 0);
        chk("t1_wrap_cnt", wrap_cnt, 1);

        // Six words into a ring of four
        do_reset();
        for (int unsigned i = 0; i < 6; i++)
            push(32'hB0 + i, 32'h1000_0000 + 4 * (i % 4));
        wait_idle();
        chk("t2_wr_idx", wr_idx, 2);
        chk("t2_wrap_cnt", wrap_cnt, 1);

        // Skewed AW/W readiness; continues at index 2
        base_aw = aw_hs_cnt; base_w = w_hs_cnt; base_b = b_cnt;
        aw_delay = 3; w_delay = 0;
        push(32'hC0, 32'h1000_0008);
        push(32'hC1, 32'h1000_000C);
        wait_idle();
        aw_delay = 0; w_delay = 3;
        push(32'hC2, 32'h1000_0000);
        push(32'hC3, 32'h1000_0004);
        wait_idle();
        aw_delay = 0; w_delay = 0;
        chk("t3_aw_count", aw_hs_cnt - base_aw, 4);
        chk("t3_w_count", w_hs_cnt - base_w, 4);
        chk("t3_b_count", b_cnt - base_b, 4);
        chk("t3_wr_idx", wr_idx, 2);
        chk("t3_wrap_cnt", wrap_cnt, 2);

        // Error responses and err_clr
        do_reset();
        bad_b_at = b_cnt + 1;
        push(32'hD0, 32'h1000_0000);
        push(32'hD1, 32'h1000_0004);
        push(32'hD2, 32'h1000_0008);
        wait_idle();
        chk("t4_err_set", err, 1);
        chk("t4_wr_idx", wr_idx, 3);
        @(negedge aclk); err_clr = 1;
        @(negedge aclk); err_clr = 0;
        chk("t4_err_cleared", err, 0);
        bad_b_at = b_cnt;
        push(32'hD3, 32'h1000_000C);
        n = 0;
        do begin
            @(negedge aclk); #1; n++;
        end while (!(axi.bvalid && axi.bready) && n < 200);
        chk("t4_bhs_seen", 32'(axi.bvalid && axi.bready), 1);
        err_clr = 1;
        @(posedge aclk);
        #1 err_clr = 0;
        wait_idle();
        bad_b_at = -1;
        chk("t4_err_coincident", err, 1);
        chk("t4_wr_idx_wrap", wr_idx, 0);
        chk("t4_wrap_cnt", wrap_cnt, 1);

        // Fill FIFO while disabled, then drain
        do_reset();
        base_addr = 32'h2000_0000; ring_len = 16'd20; enable = 0;
        base_aw = aw_hs_cnt;
        for (int unsigned i = 0; i < 16; i++)
            push(32'hE00 + i, 32'h2000_0000 + 4 * i);
        @(negedge aclk);
        chk("t5_full_s_ready", s_ready, 0);
        chk("t5_busy", busy, 1);
        any_ready = 0; any_aw = 0;
        s_valid = 1; s_data = 32'hDEAD_BEEF;
        for (int unsigned i = 0; i < 8; i++) begin
            @(negedge aclk);
            if (s_ready) any_ready = 1;
            if (axi.awvalid || axi.wvalid) any_aw = 1;
        end
        s_valid = 0;
        chk("t5_extra_refused", 32'(any_ready), 0);
        chk("t5_no_axi", 32'(any_aw), 0);
        chk("t5_no_aw_hs", aw_hs_cnt - base_aw, 0);
        enable = 1;
        wait_idle();
        chk("t5_wr_idx", wr_idx, 16);
        chk("t5_wrap_cnt", wrap_cnt, 0);

        // Asynchronous reset during ADDR_DATA
        aw_delay = 5; w_delay = 5;
        push(32'hF0, 32'h2000_0040);
        push(32'hF1, 32'h2000_0044);
        n = 0;
        while (!axi.awvalid && n < 100) begin
            @(negedge aclk); n++;
        end
        chk("t6_in_addr_data", axi.awvalid, 1);
        #2 areset = 1;
        #1;
        chk("t6_awvalid", axi.awvalid, 0);
        chk("t6_wvalid", axi.wvalid, 0);
        chk("t6_wr_idx", wr_idx, 0);
        chk("t6_busy", busy, 0);
        exp_q.delete(); cap_addr.delete(); cap_data.delete();
        aw_delay = 0; w_delay = 0;
        repeat (2) @(negedge aclk);
        areset = 0;
        ring_len = 16'd0;
        @(negedge aclk);
        chk("t6_ring0_s_ready", s_ready, 0);
        ring_len = 16'd4;
        push(32'hF2, 32'h2000_0000);
        wait_idle();
        chk("t6_post_wr_idx", wr_idx, 1);

        repeat (3) @(negedge aclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
